// File: rtl/dual_port_mem_arbiter_pkg.sv
// Shared types and defaults for the two-master memory arbiter.
// State encoding, bus widths and the timeout read pattern live here.
package dual_port_mem_arbiter_pkg;

   localparam int unsigned ARB_ADDR_WIDTH = 32;
   localparam int unsigned ARB_WORD_WIDTH = 32;
   localparam int unsigned ARB_WE_WIDTH   = 4;
   localparam logic [31:0] ARB_ERR_RDATA  = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StErr  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/dual_port_mem_arbiter_watchdog.sv
// Saturating transaction watchdog: counts stalled cycles and flags when the
// count sits at TIMEOUT_CYCLES-1. A TIMEOUT_CYCLES of 0 never flags.
module arb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_hit
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] THRESH =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_thresh;

   assign w_at_thresh = (r_cnt == THRESH);
   assign o_hit       = (TIMEOUT_CYCLES != 0) && w_at_thresh;

   // Holds at the threshold rather than wrapping back to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !w_at_thresh) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dual_port_mem_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory slave between two masters,
// with a watchdog that completes stalled transactions with an error response.
module dual_port_mem_arbiter
   import dual_port_mem_arbiter_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH     = ARB_ADDR_WIDTH,
   parameter int unsigned           WORD_WIDTH     = ARB_WORD_WIDTH,
   parameter int unsigned           TIMEOUT_CYCLES = 64,
   parameter logic [WORD_WIDTH-1:0] ERR_RDATA      = WORD_WIDTH'(ARB_ERR_RDATA)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    m0_valid_i,
   output logic                    m0_ready_o,
   input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
   input  logic [WORD_WIDTH-1:0]   m0_wdata_i,
   input  logic [ARB_WE_WIDTH-1:0] m0_we_i,
   output logic [WORD_WIDTH-1:0]   m0_rdata_o,
   output logic                    m0_err_o,
   input  logic                    m1_valid_i,
   output logic                    m1_ready_o,
   input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
   input  logic [WORD_WIDTH-1:0]   m1_wdata_i,
   input  logic [ARB_WE_WIDTH-1:0] m1_we_i,
   output logic [WORD_WIDTH-1:0]   m1_rdata_o,
   output logic                    m1_err_o,
   output logic                    s_valid_o,
   input  logic                    s_ready_i,
   output logic [ADDR_WIDTH-1:0]   s_addr_o,
   output logic [WORD_WIDTH-1:0]   s_wdata_o,
   output logic [ARB_WE_WIDTH-1:0] s_we_o,
   input  logic [WORD_WIDTH-1:0]   s_rdata_i
);

   arb_state_e r_state;
   logic       r_grant;
   logic       r_last_grant;

   logic                  w_busy;
   logic                  w_err;
   logic                  w_gnt_valid;
   logic                  w_done;
   logic                  w_hit;
   logic                  w_wd_clr;
   logic                  w_wd_en;
   logic [WORD_WIDTH-1:0] w_rdata;

   assign w_busy      = (r_state == StBusy);
   assign w_err       = (r_state == StErr);
   assign w_gnt_valid = r_grant ? m1_valid_i : m0_valid_i;

   assign w_wd_clr = !w_busy || s_ready_i;
   assign w_wd_en  = w_busy && !s_ready_i;

   arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_wd_clr),
      .i_en  (w_wd_en),
      .o_hit (w_hit)
   );

   // r_last_grant starts at 1 so master 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StIdle;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (m0_valid_i && m1_valid_i) begin
                  r_grant <= ~r_last_grant;
                  r_state <= StBusy;
               end else if (m0_valid_i) begin
                  r_grant <= 1'b0;
                  r_state <= StBusy;
               end else if (m1_valid_i) begin
                  r_grant <= 1'b1;
                  r_state <= StBusy;
               end
            end
            StBusy: begin
               if (!w_gnt_valid) begin
                  r_state <= StIdle;
               end else if (s_ready_i) begin
                  r_state      <= StIdle;
                  r_last_grant <= r_grant;
               end else if (w_hit) begin
                  r_state <= StErr;
               end
            end
            StErr: begin
               r_state      <= StIdle;
               r_last_grant <= r_grant;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_comb begin
      s_valid_o = w_busy && w_gnt_valid;
      s_addr_o  = '0;
      s_wdata_o = '0;
      s_we_o    = '0;
      if (w_busy) begin
         s_addr_o  = r_grant ? m1_addr_i  : m0_addr_i;
         s_wdata_o = r_grant ? m1_wdata_i : m0_wdata_i;
         s_we_o    = r_grant ? m1_we_i    : m0_we_i;
      end
   end

   assign w_done  = (s_valid_o && s_ready_i) || w_err;
   assign w_rdata = w_err ? ERR_RDATA : s_rdata_i;

   assign m0_ready_o = w_done && !r_grant;
   assign m1_ready_o = w_done && r_grant;
   assign m0_rdata_o = m0_ready_o ? w_rdata : '0;
   assign m1_rdata_o = m1_ready_o ? w_rdata : '0;
   assign m0_err_o   = m0_ready_o && w_err;
   assign m1_err_o   = m1_ready_o && w_err;

endmodule

// File: doc/dual_port_mem_arbiter.md
Name: dual_port_mem_arbiter

Overview:
Shares one single-port memory slave between two requesting masters, for example instruction fetch and data access, using the valid/ready handshake of the memory bus. A registered grant FSM selects one master per transaction with round-robin fairness. It forwards that master's request to the slave and routes the slave's response back. A watchdog counter ends any transaction the slave fails to complete, returning an error response to the master instead of hanging the core.

Parameters:
ADDR_WIDTH, 32, address bus width
WORD_WIDTH, 32, data bus width
TIMEOUT_CYCLES, 64, cycles in BUSY without slave ready before error completion; 0 disables watchdog
ERR_RDATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
m0_valid_i  in  1  master 0 request; held with fields until m0_ready_o
m0_ready_o  out  1  master 0 completion pulse
m0_addr_i  in  ADDR_WIDTH  master 0 address
m0_wdata_i  in  WORD_WIDTH  master 0 write data
m0_we_i  in  4  master 0 byte write enables; 0 = read
m0_rdata_o  out  WORD_WIDTH  master 0 read data, valid with m0_ready_o
m0_err_o  out  1  master 0 timeout flag, only with m0_ready_o
m1_*  same set as m0_*, for master 1
s_valid_o  out  1  request to slave
s_ready_i  in  1  slave completion
s_addr_o  out  ADDR_WIDTH  forwarded address
s_wdata_o  out  WORD_WIDTH  forwarded write data
s_we_o  out  4  forwarded byte enables
s_rdata_i  in  WORD_WIDTH  slave read data

Behaviour:
- Reset: state=IDLE, grant=0, last_grant=1 (m0 wins first tie), timeout count=0. All outputs are 0 while rst is high and in IDLE.
- FSM states:
  - IDLE: requests are sampled on the edge.
    - Only m0_valid_i high -> BUSY, grant=0.
    - Only m1_valid_i high -> BUSY, grant=1.
    - Both high -> BUSY, grant = !last_grant.
    - Neither high -> stay in IDLE.
  - BUSY:
    - s_valid_o=1; s_addr_o, s_wdata_o and s_we_o are a combinational mux of the granted master's inputs.
    - The granted master's ready_o equals s_ready_i (combinational), and its rdata_o equals s_rdata_i.
    - The non-granted master's ready_o is 0.
    - s_ready_i=1 -> IDLE, last_grant=grant, count cleared.
  - ERR (one cycle):
    - s_valid_o=0; granted master sees ready_o=1, err_o=1, rdata_o=ERR_RDATA.
    - Then -> IDLE, last_grant=grant.
- Latency: request in IDLE at edge t -> s_valid_o from t+1. Completion is seen by the master the same cycle as s_ready_i. There is one IDLE bubble between back-to-back transactions, so sustained throughput is at best one transfer per 2 cycles.
- Watchdog: the counter increments each BUSY cycle with s_ready_i=0. When the count reaches TIMEOUT_CYCLES-1 with s_ready_i still 0, the next state is ERR. The counter saturates; it never wraps.
- Simultaneous s_ready_i and timeout threshold: s_ready_i wins, normal completion, err_o=0.
- Granted master drops valid in BUSY (protocol violation): abort, IDLE next cycle, no ready_o pulse. s_valid_o follows the master's valid combinationally, so it drops the same cycle.
- Non-granted master's request is held pending and is guaranteed grant next, so the wait is at most one transaction.
- rdata_o/err_o of a master are 0 whenever its ready_o is 0.
- Reset asserted mid-transaction: immediate return to IDLE, s_valid_o=0, no ready pulse. The slave's in-flight completion after reset is ignored.

Decomposition:
- Shared package/defines: state encoding (IDLE/BUSY/ERR), ERR_RDATA default, bus width macros.
- One natural sub-module, arb_watchdog: a saturating counter with clear/enable and a threshold-hit output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- m0 read alone at addr 0x100; slave answers ready 2 cycles after s_valid_o with 0x12345678 -> s_addr_o=0x100 from cycle t+1; m0_ready_o pulses once with rdata 0x12345678; m1_ready_o stays 0.
- m0 and m1 both request continuously, each reads with 1-cycle slave -> grants alternate m0,m1,m0,m1; 4 transfers complete in 8 cycles.
- m1 write we=4'b1111 addr 0x000fffff wdata 0x41000000 -> s_we_o=4'hF and s_wdata_o=0x41000000 while BUSY; single m1_ready_o pulse.
- TIMEOUT_CYCLES=4, slave never ready -> ERR state entered after 4 BUSY cycles; m0 sees ready=1, err=1, rdata=0xDEADBEEF; next request is accepted normally.
- TIMEOUT_CYCLES=4, s_ready_i arrives exactly on the threshold cycle -> normal completion, err_o=0.
- rst pulsed while BUSY with m1 granted -> outputs 0 the same cycle; after release, a simultaneous m0/m1 request grants m0 first.
